// File: rtl/opponent_packet_parser.sv
// Receives a dibit-wide Ethernet stream and extracts the opponent's position, heading and
// status from game frames. Only frames that pass the ethertype, magic, checksum and range checks reach the outputs.
module opponent_packet_parser #(
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        axiov,
    input  logic [1:0]  axiod,
    output logic [10:0] opponent_x,
    output logic [10:0] opponent_y,
    output logic [8:0]  opponent_dir,
    output logic [7:0]  opponent_stat,
    output logic        update,
    output logic [15:0] good_count,
    output logic [15:0] bad_count
);

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, TAIL, DROP} state_t;

    state_t      state_q;
    logic        axiovPrev_q;
    logic [1:0]  dibitCnt_q;
    logic [5:0]  byteIdx_q;
    logic [5:0]  shift_q;
    logic [7:0]  etherHi_q;
    logic [7:0]  csum_q;
    logic        csumOk_q;
    logic [15:0] x_q;
    logic [15:0] y_q;
    logic [15:0] dir_q;
    logic [7:0]  stat_q;
    logic [10:0] oppX_q;
    logic [10:0] oppY_q;
    logic [8:0]  oppDir_q;
    logic [7:0]  oppStat_q;
    logic        update_q;
    logic [15:0] goodCount_q;
    logic [15:0] badCount_q;

    logic [7:0]  shift_d;
    logic        byteDone;
    logic        frameGood;

    // Earlier dibits sit in the low bits, so the newest dibit lands in [7:6].
    assign shift_d   = {axiod, shift_q};
    assign byteDone  = (dibitCnt_q == 2'd3);
    assign frameGood = (state_q == TAIL) && csumOk_q &&
                       (x_q[15:11] == 5'd0) && (y_q[15:11] == 5'd0) &&
                       (dir_q < 16'd360);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            // Starts high so a stream already valid at reset release is not taken as a frame start.
            axiovPrev_q <= 1'b1;
            dibitCnt_q  <= 2'd0;
            byteIdx_q   <= 6'd0;
            shift_q     <= 6'd0;
            etherHi_q   <= 8'd0;
            csum_q      <= 8'd0;
            csumOk_q    <= 1'b0;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            dir_q       <= 16'd0;
            stat_q      <= 8'd0;
            oppX_q      <= 11'd0;
            oppY_q      <= 11'd0;
            oppDir_q    <= 9'd0;
            oppStat_q   <= 8'd0;
            update_q    <= 1'b0;
            goodCount_q <= 16'd0;
            badCount_q  <= 16'd0;
        end else begin
            axiovPrev_q <= axiov;
            update_q    <= 1'b0;
            if (state_q == IDLE) begin
                if (axiov && !axiovPrev_q) begin
                    state_q    <= HEADER;
                    shift_q    <= shift_d[7:2];
                    dibitCnt_q <= 2'd1;
                    byteIdx_q  <= 6'd0;
                end
            end else if (!axiov) begin
                state_q <= IDLE;
                if (frameGood) begin
                    oppX_q    <= x_q[10:0];
                    oppY_q    <= y_q[10:0];
                    oppDir_q  <= dir_q[8:0];
                    oppStat_q <= stat_q;
                    update_q  <= 1'b1;
                    if (goodCount_q != 16'hFFFF) goodCount_q <= goodCount_q + 16'd1;
                end else begin
                    if (badCount_q != 16'hFFFF) badCount_q <= badCount_q + 16'd1;
                end
            end else begin
                shift_q    <= shift_d[7:2];
                dibitCnt_q <= dibitCnt_q + 2'd1;
                if (byteDone) begin
                    if (byteIdx_q != 6'd63) byteIdx_q <= byteIdx_q + 6'd1;
                    case (state_q)
                        HEADER: begin
                            if (byteIdx_q == 6'd12) etherHi_q <= shift_d;
                            else if (byteIdx_q == 6'd13)
                                state_q <= ({etherHi_q, shift_d} == ETHERTYPE) ? PAYLOAD : DROP;
                        end
                        PAYLOAD: begin
                            case (byteIdx_q)
                                6'd14: begin
                                    csum_q <= shift_d;
                                    if (shift_d != MAGIC) state_q <= DROP;
                                end
                                6'd15: begin x_q[15:8]   <= shift_d; csum_q <= csum_q ^ shift_d; end
                                6'd16: begin x_q[7:0]    <= shift_d; csum_q <= csum_q ^ shift_d; end
                                6'd17: begin y_q[15:8]   <= shift_d; csum_q <= csum_q ^ shift_d; end
                                6'd18: begin y_q[7:0]    <= shift_d; csum_q <= csum_q ^ shift_d; end
                                6'd19: begin dir_q[15:8] <= shift_d; csum_q <= csum_q ^ shift_d; end
                                6'd20: begin dir_q[7:0]  <= shift_d; csum_q <= csum_q ^ shift_d; end
                                6'd21: begin stat_q      <= shift_d; csum_q <= csum_q ^ shift_d; end
                                6'd22: begin
                                    csumOk_q <= (shift_d == csum_q);
                                    state_q  <= TAIL;
                                end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign opponent_x    = oppX_q;
    assign opponent_y    = oppY_q;
    assign opponent_dir  = oppDir_q;
    assign opponent_stat = oppStat_q;
    assign update        = update_q;
    assign good_count    = goodCount_q;
    assign bad_count     = badCount_q;

endmodule
